// File: rtl/button_debouncer.sv
// button_debouncer: conditions the four raw snake-game push buttons.
// Each button is normalized to active-high, passed through a two-flop
// synchronizer, and then checked by a stable-time counter. The counter
// accepts a new state only after it has held for DEBOUNCE_CYCLES cycles.
// Build option: define BUTTON_PULSE_EN to make each output a one-cycle
// press pulse. When it is undefined (the default), each output is the
// debounced level.

// Per-button synchronizer, stable-time counter and output register.
module button_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,   // raw input, already normalized to active-high
  output logic out
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic             stable;
  logic             next_stable;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  // The accepted state flips only on the last cycle of an uninterrupted mismatch run.
  always_comb begin
    next_stable = stable;
    if (s2 != stable && cnt == CNT_MAX) next_stable = s2;
  end

  // Stable-time counter: any agreement with the accepted state restarts the run,
  // so the counter stops at CNT_MAX and can never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      stable <= next_stable;
      if (s2 == stable || cnt == CNT_MAX) cnt <= '0;
      else                                cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef BUTTON_PULSE_EN
  logic pulse;

  // One registered pulse per accepted press. Releases and held buttons stay quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) pulse <= 1'b0;
    else        pulse <= next_stable & ~stable;
  end

  assign out = pulse;
`else
  assign out = stable;
`endif
endmodule

// Top level: four independent button lanes. Simultaneous presses are passed
// through unchanged.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_left,
  input  logic key_right,
  input  logic key_up,
  input  logic key_down,
  output logic left,
  output logic right,
  output logic up,
  output logic down
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] norm;
  logic [NUM_LANES-1:0] outs;

  assign raw  = {key_down, key_up, key_right, key_left};
  assign norm = ACTIVE_LOW ? ~raw : raw;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    button_debouncer_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (norm[i]),
      .out   (outs[i])
    );
  end

  assign left  = outs[0];
  assign right = outs[1];
  assign up    = outs[2];
  assign down  = outs[3];
endmodule
